// File: rtl/pool_window_feeder.sv
// Streams a raster feature map and presents 2-pixel pairs to a max comparator.
// Optional horizontal pairing (port hpair) is enabled by defining POOL_FEEDER_HPAIR_EN.
module pool_window_feeder #(
  parameter int DATA_W   = 20,
  parameter int ROW_LEN  = 8,
  parameter int NUM_ROWS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef POOL_FEEDER_HPAIR_EN
  input  logic              hpair,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] ifm_pair0,
  output logic [DATA_W-1:0] ifm_pair1,
  output logic              pair_valid,
  output logic              pair_last
);

  localparam int CW = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] line_buf [ROW_LEN];

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              emit;
  logic [DATA_W-1:0] pair0_next;

  assign accept   = s_valid & s_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

`ifdef POOL_FEEDER_HPAIR_EN
  logic              h_mode;
  logic              h_now;
  logic [DATA_W-1:0] held;

  // The mode latched at the start of a frame governs every pixel of it,
  // including the first one, which sees hpair directly.
  assign h_now = (row == '0 && col == '0) ? hpair : h_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_mode <= 1'b0;
      held   <= '0;
    end else if (accept) begin
      if (row == '0 && col == '0) h_mode <= hpair;
      if (!col[0])                held   <= s_data;
    end
  end
`endif

  // NOTE: always_comb gives every output a default first so no latch is inferred.
  always_comb begin
    emit       = accept && (state == PAIR);
    pair0_next = line_buf[col];
`ifdef POOL_FEEDER_HPAIR_EN
    if (h_now) begin
      emit       = accept && col[0];
      pair0_next = held;
    end
`endif
  end

  // NOTE: the line buffer has no reset; every entry is rewritten in FILL before
  // PAIR can read it, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (accept && state == FILL) line_buf[col] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      s_ready    <= 1'b0;
      ifm_pair0  <= '0;
      ifm_pair1  <= '0;
      pair_valid <= 1'b0;
      pair_last  <= 1'b0;
    end else begin
      s_ready    <= 1'b1;
      pair_valid <= 1'b0;
      pair_last  <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col   <= '0;
          row   <= row_last ? '0 : row + 1'b1;
          state <= (state == FILL) ? PAIR : FILL;
        end else begin
          col <= col + 1'b1;
        end
        if (emit) begin
          ifm_pair0  <= pair0_next;
          ifm_pair1  <= s_data;
          pair_valid <= 1'b1;
          pair_last  <= row_last && col_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder on a 4x2 frame: table of per-cycle vectors
// plus hand sequences for reset and (when POOL_FEEDER_HPAIR_EN is defined) hpair.
module tb_pool_window_feeder;

  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] ifm_pair0;
  logic [DW-1:0] ifm_pair1;
  logic          pair_valid;
  logic          pair_last;
`ifdef POOL_FEEDER_HPAIR_EN
  logic          hpair = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          pv;
    logic          pl;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t vecs[$];

  pool_window_feeder #(.DATA_W(DW), .ROW_LEN(4), .NUM_ROWS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef POOL_FEEDER_HPAIR_EN
    .hpair      (hpair),
`endif
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .ifm_pair0  (ifm_pair0),
    .ifm_pair1  (ifm_pair1),
    .pair_valid (pair_valid),
    .pair_last  (pair_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input int d, input logic pv, input logic pl,
                     input int e0, input int e1);
    vec_t t;
    t.v = v; t.d = DW'(d); t.pv = pv; t.pl = pl; t.e0 = DW'(e0); t.e1 = DW'(e1);
    vecs.push_back(t);
  endtask

  // Drive one cycle of input, then compare outputs at the following falling edge.
  task automatic step(input vec_t t, input string tag);
    s_valid = t.v;
    s_data  = t.d;
    @(negedge clk);
    check({tag, ".ready"}, 32'(s_ready), 32'd1);
    check({tag, ".pv"}, 32'(pair_valid), 32'(t.pv));
    check({tag, ".pl"}, 32'(pair_last), 32'(t.pl));
    check({tag, ".p0"}, 32'(ifm_pair0), 32'(t.e0));
    check({tag, ".p1"}, 32'(ifm_pair1), 32'(t.e1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, 32'(s_ready), 32'd0);
    check({tag, ".pv"}, 32'(pair_valid), 32'd0);
    check({tag, ".pl"}, 32'(pair_last), 32'd0);
    check({tag, ".p0"}, 32'(ifm_pair0), 32'd0);
    check({tag, ".p1"}, 32'(ifm_pair1), 32'd0);
  endtask

  initial begin
    vec_t t;
    // Frame A: continuous 1..8.
    for (int i = 1; i <= 4; i++) add(1, i, 0, 0, 0, 0);
    add(1, 5, 1, 0, 1, 5);
    add(1, 6, 1, 0, 2, 6);
    add(1, 7, 1, 0, 3, 7);
    add(1, 8, 1, 1, 4, 8);
    // Frame B: back-to-back 11..18.
    for (int i = 11; i <= 14; i++) add(1, i, 0, 0, 4, 8);
    add(1, 15, 1, 0, 11, 15);
    add(1, 16, 1, 0, 12, 16);
    add(1, 17, 1, 0, 13, 17);
    add(1, 18, 1, 1, 14, 18);
    // Frame C: 1..8 with 3 idle cycles after pixels 2 and 6.
    add(1, 1, 0, 0, 14, 18);
    add(1, 2, 0, 0, 14, 18);
    for (int i = 0; i < 3; i++) add(0, 99, 0, 0, 14, 18);
    add(1, 3, 0, 0, 14, 18);
    add(1, 4, 0, 0, 14, 18);
    add(1, 5, 1, 0, 1, 5);
    add(1, 6, 1, 0, 2, 6);
    for (int i = 0; i < 3; i++) add(0, 77, 0, 0, 2, 6);
    add(1, 7, 1, 0, 3, 7);
    add(1, 8, 1, 1, 4, 8);

    // Reset at power-up, checked between clock edges.
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Partial frame 1..6, then asynchronous reset mid-frame.
    for (int i = 1; i <= 6; i++) begin
      t.v = 1; t.d = DW'(i); t.pv = (i >= 5); t.pl = 0;
      t.e0 = (i >= 5) ? DW'(i - 4) : DW'(4);
      t.e1 = (i >= 5) ? DW'(i) : DW'(8);
      step(t, $sformatf("part%0d", i));
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 20'd55;
    @(negedge clk);
    check_reset_outputs("inrst");
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    // Fresh frame 21..28 after reset release.
    for (int i = 21; i <= 28; i++) begin
      t.v  = 1; t.d = DW'(i);
      t.pv = (i >= 25);
      t.pl = (i == 28);
      t.e0 = (i >= 25) ? DW'(i - 4) : '0;
      t.e1 = (i >= 25) ? DW'(i) : '0;
      step(t, $sformatf("post%0d", i));
    end

`ifdef POOL_FEEDER_HPAIR_EN
    // Horizontal pairing selected at row 0 column 0; later toggles are ignored.
    for (int i = 1; i <= 8; i++) begin
      hpair = (i == 1) ? 1'b1 : logic'(i % 2);
      t.v  = 1; t.d = DW'(i);
      t.pv = (i % 2 == 0);
      t.pl = (i == 8);
      t.e0 = (i % 2 == 0) ? DW'(i - 1) : ((i == 1) ? DW'(24) : DW'(i - 2));
      t.e1 = (i % 2 == 0) ? DW'(i) : ((i == 1) ? DW'(28) : DW'(i - 1));
      step(t, $sformatf("hp%0d", i));
    end
    hpair = 1'b0;
`endif

    s_valid = 1'b0;
    @(negedge clk);
    check("idle.pv", 32'(pair_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
